// File: rtl/alu_pkg.sv
// Shared opcode values, FSM state encoding and flag bundle for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    HOLD = 2'b10
  } state_e;

  typedef struct packed {
    logic cout;
    logic cf;
    logic zf;
    logic sf;
  } flags_t;

endpackage

// File: rtl/alu_seq_param_push_sync.sv
// Push-button conditioner: 2-flop synchroniser plus rising-edge pulse, or a plain
// wire-through when the pushes already arrive as clean single-cycle pulses.
module push_sync #(
  parameter bit SYNC = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  output logic pulse_o
);

  generate
    if (SYNC) begin : g_sync
      // [0],[1] synchronise; [2] remembers the previous synchronised level.
      logic [2:0] sh_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sh_q <= '0;
        end else begin
          sh_q <= {sh_q[1:0], push_i};
        end
      end

      assign pulse_o = sh_q[1] & ~sh_q[2];
    end else begin : g_pass
      assign pulse_o = push_i;
    end
  endgenerate

endmodule

// File: rtl/alu_seq_param.sv
// Parametrised sequential ALU: operands/opcode loaded from a shared bus by pushes,
// one operation per start, result held under a valid/ready handshake.
module alu_seq_param
  import alu_pkg::*;
#(
  parameter int unsigned W        = 4,
  parameter bit          SIGN_MAG = 1'b1,
  parameter bit          SYNC     = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] no,
  input  logic         push1,
  input  logic         push2,
  input  logic         push3,
  input  logic         start,
  output logic         busy,
  output logic [W-1:0] res,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         cout,
  output logic         cf,
  output logic         zf,
  output logic         sf
);

  localparam int unsigned OPW   = (W < 3) ? W : 3;
  localparam logic [W:0]   ONE_X = (W+1)'(1);
  localparam logic [W-1:0] ONE_W = W'(1);

  logic p1, p2, p3;

  push_sync #(.SYNC(SYNC)) u_sync1 (.clk(clk), .rst_n(rst_n), .push_i(push1), .pulse_o(p1));
  push_sync #(.SYNC(SYNC)) u_sync2 (.clk(clk), .rst_n(rst_n), .push_i(push2), .pulse_o(p2));
  push_sync #(.SYNC(SYNC)) u_sync3 (.clk(clk), .rst_n(rst_n), .push_i(push3), .pulse_o(p3));

  // Loaded registers (free to change at any time) and the snapshot the EXEC cycle uses.
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]   op_q, op_d;
  logic [W-1:0] sa_q, sb_q;
  logic [2:0]   sop_q;

  logic         start_q, start_d;
  state_e       state_q, state_d;
  logic         snap_en, exec_en;

  logic [W-1:0] res_q, alu_res;
  flags_t       flags_q, alu_flags;

  logic [2:0]   no_op;
  logic [W:0]   sum_w, diff_w;

  assign no_op = 3'(no[OPW-1:0]);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    op_d = op_q;
    if (p1) begin
      a_d = no;
    end else if (p2) begin
      b_d = no;
    end else if (p3) begin
      op_d = no_op;
    end
  end

  // start is registered before the FSM sees it; only a request made while idle is kept.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    snap_en = 1'b0;
    exec_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        start_d = start;
        if (start_q) begin
          state_d = EXEC;
          snap_en = 1'b1;
        end
      end
      EXEC: begin
        exec_en = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sum_w  = {1'b0, sa_q} + {1'b0, sb_q};
  assign diff_w = {1'b0, sa_q} + {1'b0, ~sb_q} + ONE_X;

  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    unique case (sop_q)
      OP_ADD: begin
        alu_res        = sum_w[W-1:0];
        alu_flags.cout = sum_w[W];
        alu_flags.cf   = (sa_q[W-1] == sb_q[W-1]) && (sum_w[W-1] != sa_q[W-1]);
        alu_flags.sf   = sum_w[W-1];
      end
      OP_SUB, OP_CMP: begin
        alu_flags.cout = diff_w[W];
        alu_flags.cf   = (sa_q[W-1] != sb_q[W-1]) && (diff_w[W-1] != sa_q[W-1]);
        alu_flags.sf   = diff_w[W-1];
        if (sop_q == OP_CMP) begin
          alu_res = sa_q;
        end else if (SIGN_MAG && diff_w[W-1]) begin
          alu_res = ~diff_w[W-1:0] + ONE_W;
        end else begin
          alu_res = diff_w[W-1:0];
        end
      end
      OP_AND: begin
        alu_res      = sa_q & sb_q;
        alu_flags.sf = alu_res[W-1];
      end
      OP_OR: begin
        alu_res      = sa_q | sb_q;
        alu_flags.sf = alu_res[W-1];
      end
      OP_XOR: begin
        alu_res      = sa_q ^ sb_q;
        alu_flags.sf = alu_res[W-1];
      end
      OP_SHL: begin
        alu_res        = {sa_q[W-2:0], 1'b0};
        alu_flags.cout = sa_q[W-1];
        alu_flags.sf   = alu_res[W-1];
      end
      OP_SHR: begin
        alu_res      = {1'b0, sa_q[W-1:1]};
        alu_flags.sf = alu_res[W-1];
      end
      default: alu_res = '0;
    endcase
    // CMP leaves res = A, so its zero flag reports equality of the operands instead.
    alu_flags.zf = (sop_q == OP_CMP) ? (diff_w[W-1:0] == '0) : (alu_res == '0);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      sop_q   <= '0;
      start_q <= 1'b0;
      state_q <= IDLE;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      start_q <= start_d;
      state_q <= state_d;
      if (snap_en) begin
        sa_q  <= a_q;
        sb_q  <= b_q;
        sop_q <= op_q;
      end
      if (exec_en) begin
        res_q   <= alu_res;
        flags_q <= alu_flags;
      end
    end
  end

  assign res       = res_q;
  assign cout      = flags_q.cout;
  assign cf        = flags_q.cf;
  assign zf        = flags_q.zf;
  assign sf        = flags_q.sf;
  assign res_valid = (state_q == HOLD);
  assign busy      = (state_q == EXEC) || (state_q == HOLD);

endmodule
